// File: rtl/y86_execute_stage_if.sv
// Handshake and data bundle between decode, the Y86 execute stage and memory.
// The stage connects through the slave modport; its environment uses master.
interface y86_execute_stage_if #(
  parameter int DATA_WID = 64
);
  logic                in_valid;
  logic                in_ready;
  logic [3:0]          icode;
  logic [3:0]          ifun;
  logic [DATA_WID-1:0] valA;
  logic [DATA_WID-1:0] valB;
  logic [DATA_WID-1:0] valC;
  logic                cc_en;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_WID-1:0] valE;
  logic                cnd;
  logic [3:0]          out_icode;
  logic [DATA_WID-1:0] out_valA;
  logic                err;
  logic [3:0]          CC;

  modport master (
    output in_valid, icode, ifun, valA, valB, valC, cc_en, out_ready,
    input  in_ready, out_valid, valE, cnd, out_icode, out_valA, err, CC
  );

  modport slave (
    input  in_valid, icode, ifun, valA, valB, valC, cc_en, out_ready,
    output in_ready, out_valid, valE, cnd, out_icode, out_valA, err, CC
  );
endinterface

// File: rtl/y86_execute_stage.sv
// Y86 execute stage: operand select, ALU, condition codes and condition evaluation.
// Define Y86_EXEC_MUL_EN to build the iterative shift-add multiplier for OP ifun 4.
module y86_execute_stage #(
  parameter int DATA_WID = 64
) (
  input logic                clk,
  input logic                rst_n,
  y86_execute_stage_if.slave bus
);
  localparam int MSB = DATA_WID - 1;

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_XOR = 4'd3;

  localparam logic [DATA_WID-1:0] WORD_POS = DATA_WID'(DATA_WID / 8);
  localparam logic [DATA_WID-1:0] WORD_NEG = -WORD_POS;

`ifdef Y86_EXEC_MUL_EN
  localparam logic [3:0] FN_MUL     = 4'd4;
  localparam logic [3:0] OP_FN_MAX  = 4'd4;
  localparam int         CNT_W      = $clog2(DATA_WID);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WID - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WAIT = 2'd2
  } state_t;
`else
  localparam logic [3:0] OP_FN_MAX  = 4'd3;
`endif

  // Standard Y86 branch/move conditions over {ZF,SF,OF,CF}.
  function automatic logic cond_eval(input logic [3:0] fn, input logic [3:0] cc);
    logic lt;
    lt = cc[2] ^ cc[1];
    case (fn)
      4'd0:    cond_eval = 1'b1;
      4'd1:    cond_eval = lt | cc[3];
      4'd2:    cond_eval = lt;
      4'd3:    cond_eval = cc[3];
      4'd4:    cond_eval = ~cc[3];
      4'd5:    cond_eval = ~lt;
      4'd6:    cond_eval = ~lt & ~cc[3];
      default: cond_eval = 1'b0;
    endcase
  endfunction

  logic [DATA_WID-1:0] op_a_s, op_b_s, alu_res_s, vale_s;
  logic [DATA_WID:0]   sum_s, diff_s;
  logic [3:0]          alu_fn_s, new_cc_s;
  logic                alu_of_s, alu_cf_s, is_cond_s, err_s, cnd_s, cc_wr_s;
  logic                out_free_s, accept_s, in_ready_s;

  logic                out_valid_q, out_valid_d;
  logic [DATA_WID-1:0] vale_q, vale_d;
  logic                cnd_q, cnd_d;
  logic                err_q, err_d;
  logic [3:0]          out_icode_q, out_icode_d;
  logic [DATA_WID-1:0] out_vala_q, out_vala_d;
  logic [3:0]          cc_q, cc_d;

`ifdef Y86_EXEC_MUL_EN
  state_t              state_q, state_d;
  logic [DATA_WID-1:0] mcand_q, mcand_d;
  logic [DATA_WID-1:0] mplier_q, mplier_d;
  logic [DATA_WID-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_WID-1:0] mul_vala_q, mul_vala_d;
  logic                mul_cc_en_q, mul_cc_en_d;
  logic [DATA_WID-1:0] acc_step_s, mul_res_s;
  logic                is_mul_s, mul_load_s;
`endif

  // Operand selection by instruction class.
  always_comb begin
    op_a_s = '0;
    op_b_s = '0;
    case (bus.icode)
      I_OP, I_CMOV:             op_a_s = bus.valA;
      I_IRMOV, I_RMMOV, I_MRMOV: op_a_s = bus.valC;
      I_CALL, I_PUSH:           op_a_s = WORD_NEG;
      I_RET, I_POP:             op_a_s = WORD_POS;
      default:                  op_a_s = '0;
    endcase
    case (bus.icode)
      I_OP, I_RMMOV, I_MRMOV, I_CALL, I_PUSH, I_RET, I_POP: op_b_s = bus.valB;
      default:                                              op_b_s = '0;
    endcase
  end

  // ALU, flag generation, error decode and condition evaluation.
  always_comb begin
    sum_s     = {1'b0, op_a_s} + {1'b0, op_b_s};
    diff_s    = {1'b0, op_b_s} - {1'b0, op_a_s};
    alu_fn_s  = (bus.icode == I_OP) ? bus.ifun : FN_ADD;
    alu_res_s = '0;
    alu_of_s  = 1'b0;
    alu_cf_s  = 1'b0;
    case (alu_fn_s)
      FN_ADD: begin
        alu_res_s = sum_s[MSB:0];
        alu_of_s  = (op_a_s[MSB] == op_b_s[MSB]) & (sum_s[MSB] != op_a_s[MSB]);
        alu_cf_s  = sum_s[DATA_WID];
      end
      FN_SUB: begin
        alu_res_s = diff_s[MSB:0];
        alu_of_s  = (op_a_s[MSB] != op_b_s[MSB]) & (diff_s[MSB] != op_b_s[MSB]);
        alu_cf_s  = diff_s[DATA_WID];
      end
      FN_AND:  alu_res_s = op_a_s & op_b_s;
      FN_XOR:  alu_res_s = op_a_s ^ op_b_s;
      default: alu_res_s = '0;
    endcase

    is_cond_s = (bus.icode == I_CMOV) | (bus.icode == I_JXX);
    err_s     = (bus.icode > I_POP)
              | ((bus.icode == I_OP) & (bus.ifun > OP_FN_MAX))
              | (is_cond_s & (bus.ifun > 4'd6));
    vale_s    = err_s ? '0 : alu_res_s;
    // Conditions see the register value, never this instruction's own update.
    cnd_s     = is_cond_s & ~err_s & cond_eval(bus.ifun, cc_q);
    new_cc_s  = {(alu_res_s == '0), alu_res_s[MSB], alu_of_s, alu_cf_s};
    cc_wr_s   = (bus.icode == I_OP) & bus.cc_en & ~err_s;
  end

  // Handshake, output register load and multiplier sequencing.
  always_comb begin
    out_valid_d = out_valid_q;
    vale_d      = vale_q;
    cnd_d       = cnd_q;
    err_d       = err_q;
    out_icode_d = out_icode_q;
    out_vala_d  = out_vala_q;
    cc_d        = cc_q;
    out_free_s  = ~out_valid_q | bus.out_ready;
`ifdef Y86_EXEC_MUL_EN
    in_ready_s  = (state_q == S_IDLE) & out_free_s;
`else
    in_ready_s  = out_free_s;
`endif
    accept_s    = bus.in_valid & in_ready_s;

    if (out_valid_q & bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

`ifdef Y86_EXEC_MUL_EN
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mul_vala_d  = mul_vala_q;
    mul_cc_en_d = mul_cc_en_q;
    is_mul_s    = (bus.icode == I_OP) & (bus.ifun == FN_MUL);
    acc_step_s  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    // The final step's sum is forwarded so the result lands on the last MUL edge.
    mul_res_s   = (state_q == S_MUL) ? acc_step_s : acc_q;
    mul_load_s  = out_free_s & (((state_q == S_MUL) & (cnt_q == CNT_LAST)) | (state_q == S_WAIT));

    if (mul_load_s) begin
      out_valid_d = 1'b1;
      vale_d      = mul_res_s;
      cnd_d       = 1'b0;
      err_d       = 1'b0;
      out_icode_d = I_OP;
      out_vala_d  = mul_vala_q;
      if (mul_cc_en_q) begin
        cc_d = {(mul_res_s == '0), mul_res_s[MSB], 2'b00};
      end else begin
        cc_d = cc_q;
      end
    end else if (accept_s & is_mul_s) begin
      mcand_d     = op_a_s;
      mplier_d    = op_b_s;
      acc_d       = '0;
      cnt_d       = '0;
      mul_vala_d  = bus.valA;
      mul_cc_en_d = bus.cc_en;
    end else if (accept_s) begin
      out_valid_d = 1'b1;
      vale_d      = vale_s;
      cnd_d       = cnd_s;
      err_d       = err_s;
      out_icode_d = bus.icode;
      out_vala_d  = bus.valA;
      cc_d        = cc_wr_s ? new_cc_s : cc_q;
    end else begin
      cc_d = cc_q;
    end

    case (state_q)
      S_IDLE: begin
        if (accept_s & is_mul_s) begin
          state_d = S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        acc_d    = acc_step_s;
        if (cnt_q == CNT_LAST) begin
          state_d = out_free_s ? S_IDLE : S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (out_free_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
`else
    if (accept_s) begin
      out_valid_d = 1'b1;
      vale_d      = vale_s;
      cnd_d       = cnd_s;
      err_d       = err_s;
      out_icode_d = bus.icode;
      out_vala_d  = bus.valA;
      cc_d        = cc_wr_s ? new_cc_s : cc_q;
    end else begin
      cc_d = cc_q;
    end
`endif
  end

  // State registers; reset abandons any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      vale_q      <= '0;
      cnd_q       <= 1'b0;
      err_q       <= 1'b0;
      out_icode_q <= I_NOP;
      out_vala_q  <= '0;
      cc_q        <= 4'b1000;
`ifdef Y86_EXEC_MUL_EN
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_vala_q  <= '0;
      mul_cc_en_q <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      vale_q      <= vale_d;
      cnd_q       <= cnd_d;
      err_q       <= err_d;
      out_icode_q <= out_icode_d;
      out_vala_q  <= out_vala_d;
      cc_q        <= cc_d;
`ifdef Y86_EXEC_MUL_EN
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mul_vala_q  <= mul_vala_d;
      mul_cc_en_q <= mul_cc_en_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.valE      = vale_q;
  assign bus.cnd       = cnd_q;
  assign bus.err       = err_q;
  assign bus.out_icode = out_icode_q;
  assign bus.out_valA  = out_vala_q;
  assign bus.CC        = cc_q;
endmodule
